// File: rtl/conv_window_if.sv
// conv_window_if
//   Stream-side handshake and window-tag bundle of the 3x3 convolution window
//   sequencer.
//   s_valid/s_ready : input feature-map beat handshake (one 8-channel group/beat)
//   m_ready         : downstream (MAC array) can take a window beat next cycle
//   win_valid       : window beat valid, aligned with delay-line dout
//   win_cg/col/row  : channel group / bottom-right column / bottom-right row
//   win_last        : final window beat of the frame
//   Modports: master = stream source / window sink side, slave = controller.
interface conv_window_if #(
  parameter int unsigned COL_W = 10,
  parameter int unsigned ROW_W = 10,
  parameter int unsigned CG_W  = 8
);
  logic             s_valid;
  logic             s_ready;
  logic             m_ready;
  logic             win_valid;
  logic [CG_W-1:0]  win_cg;
  logic [COL_W-1:0] win_col;
  logic [ROW_W-1:0] win_row;
  logic             win_last;

  modport master (
    output s_valid, m_ready,
    input  s_ready, win_valid, win_cg, win_col, win_row, win_last
  );

  modport slave (
    input  s_valid, m_ready,
    output s_ready, win_valid, win_cg, win_col, win_row, win_last
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl
//   Sequencer for the 3x3 convolution window front end. Walks the input
//   feature-map stream in channel-group, column, row order, drives the
//   enable/depth/clear of the pixel- and row-delay lines, and tags each
//   accepted beat with its window coordinates (one cycle later, matching the
//   delay lines' registered dout).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   cfg_start       : start pulse, cfg_* sampled in the same cycle
//   cfg_cin_groups  : Cin/8, legal 1..128
//   cfg_width       : image width, legal >= 3
//   cfg_height      : image height, legal >= 3
//   abort           : cancel the frame in progress (CLEAR or RUN)
//   bus             : stream handshake and window tags (slave side)
//   lb_clr          : clear pulse to the delay lines
//   lb_en           : shift enable to all delay lines
//   lb_px_depth     : pixel-delay depth (= cin_groups)
//   lb_row_depth    : row-delay depth (= width * cin_groups)
//   busy            : controller not idle
//   done            : one-cycle end-of-frame pulse
//   cfg_err         : sticky illegal-config flag, cleared by a legal start
module conv_window_ctrl #(
  parameter int unsigned COL_W = 10,
  parameter int unsigned ROW_W = 10,
  parameter int unsigned CG_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic [CG_W-1:0]        cfg_cin_groups,
  input  logic [COL_W-1:0]       cfg_width,
  input  logic [ROW_W-1:0]       cfg_height,
  input  logic                   abort,
  conv_window_if.slave           bus,
  output logic                   lb_clr,
  output logic                   lb_en,
  output logic [CG_W-1:0]        lb_px_depth,
  output logic [COL_W+CG_W-1:0]  lb_row_depth,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  localparam int unsigned CG_MAX = 128;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, FINISH} state_e;

  state_e                  state_q;
  logic [CG_W-1:0]         cin_q;
  logic [COL_W-1:0]        width_q;
  logic [ROW_W-1:0]        height_q;
  logic [CG_W-1:0]         cg_q;
  logic [COL_W-1:0]        col_q;
  logic [ROW_W-1:0]        row_q;
  logic [CG_W-1:0]         px_depth_q;
  logic [COL_W+CG_W-1:0]   row_depth_q;
  logic                    lb_clr_q;
  logic                    done_q;
  logic                    cfg_err_q;
  logic                    win_valid_q;
  logic                    win_last_q;
  logic [CG_W-1:0]         win_cg_q;
  logic [COL_W-1:0]        win_col_q;
  logic [ROW_W-1:0]        win_row_q;

  logic cfg_legal;
  logic accept;
  logic cg_wrap;
  logic col_wrap;
  logic row_last;
  logic frame_last;
  logic in_window;

  assign cfg_legal  = (cfg_cin_groups != '0) && (32'(cfg_cin_groups) <= CG_MAX) &&
                      (cfg_width >= COL_W'(3)) && (cfg_height >= ROW_W'(3));
  assign accept     = (state_q == RUN) && bus.s_valid && bus.m_ready;
  assign cg_wrap    = (cg_q  == cin_q    - CG_W'(1));
  assign col_wrap   = (col_q == width_q  - COL_W'(1));
  assign row_last   = (row_q == height_q - ROW_W'(1));
  assign frame_last = cg_wrap && col_wrap && row_last;
  assign in_window  = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cin_q       <= '0;
      width_q     <= '0;
      height_q    <= '0;
      cg_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      px_depth_q  <= '0;
      row_depth_q <= '0;
      lb_clr_q    <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_cg_q    <= '0;
      win_col_q   <= '0;
      win_row_q   <= '0;
    end else begin
      // Pulse outputs default low; tags hold their last values.
      lb_clr_q    <= 1'b0;
      done_q      <= 1'b0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cfg_start) begin
            if (cfg_legal) begin
              cin_q       <= cfg_cin_groups;
              width_q     <= cfg_width;
              height_q    <= cfg_height;
              px_depth_q  <= cfg_cin_groups;
              row_depth_q <= (COL_W+CG_W)'(cfg_width) * (COL_W+CG_W)'(cfg_cin_groups);
              cfg_err_q   <= 1'b0;
              lb_clr_q    <= 1'b1;
              state_q     <= CLEAR;
            end else begin
              cfg_err_q   <= 1'b1;
              state_q     <= FINISH;
            end
          end
        end
        CLEAR: begin
          cg_q  <= '0;
          col_q <= '0;
          row_q <= '0;
          if (abort) begin
            lb_clr_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            state_q  <= RUN;
          end
        end
        RUN: begin
          // Abort wins over a beat accepted in the same cycle: the beat is
          // dropped and the delay lines are cleared instead.
          if (abort) begin
            lb_clr_q <= 1'b1;
            state_q  <= IDLE;
          end else if (accept) begin
            win_valid_q <= in_window;
            win_last_q  <= frame_last;
            win_cg_q    <= cg_q;
            win_col_q   <= col_q;
            win_row_q   <= row_q;
            if (cg_wrap) begin
              cg_q <= '0;
              if (col_wrap) begin
                col_q <= '0;
                row_q <= row_q + ROW_W'(1);
              end else begin
                col_q <= col_q + COL_W'(1);
              end
            end else begin
              cg_q <= cg_q + CG_W'(1);
            end
            if (frame_last) begin
              state_q <= FINISH;
            end
          end
        end
        FINISH: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_ready   = (state_q == RUN) && bus.m_ready;
  assign lb_en         = bus.s_valid && bus.s_ready;
  assign bus.win_valid = win_valid_q;
  assign bus.win_last  = win_last_q;
  assign bus.win_cg    = win_cg_q;
  assign bus.win_col   = win_col_q;
  assign bus.win_row   = win_row_q;
  assign lb_clr        = lb_clr_q;
  assign lb_px_depth   = px_depth_q;
  assign lb_row_depth  = row_depth_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl
//   Table of frame configurations applied in a loop; a scoreboard queue holds
//   the window tags expected from each accepted beat and a negedge monitor
//   pops/compares them whenever win_valid is seen. Hand-written sequences
//   cover reset, and reset in the middle of a frame.
module tb_conv_window_ctrl;
  localparam int unsigned COL_W = 10;
  localparam int unsigned ROW_W = 10;
  localparam int unsigned CG_W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  cfg_start;
  logic [CG_W-1:0]       cfg_cin_groups;
  logic [COL_W-1:0]      cfg_width;
  logic [ROW_W-1:0]      cfg_height;
  logic                  abort;
  logic                  lb_clr;
  logic                  lb_en;
  logic [CG_W-1:0]       lb_px_depth;
  logic [COL_W+CG_W-1:0] lb_row_depth;
  logic                  busy;
  logic                  done;
  logic                  cfg_err;

  conv_window_if #(.COL_W(COL_W), .ROW_W(ROW_W), .CG_W(CG_W)) bus ();

  conv_window_ctrl #(.COL_W(COL_W), .ROW_W(ROW_W), .CG_W(CG_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_start      (cfg_start),
    .cfg_cin_groups (cfg_cin_groups),
    .cfg_width      (cfg_width),
    .cfg_height     (cfg_height),
    .abort          (abort),
    .bus            (bus),
    .lb_clr         (lb_clr),
    .lb_en          (lb_en),
    .lb_px_depth    (lb_px_depth),
    .lb_row_depth   (lb_row_depth),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err)
  );

  // {cg, col, row, last}
  typedef logic [28:0] tag_t;

  typedef struct {
    int cin;
    int w;
    int h;
    int mode;      // 0: all high, 1: m_ready toggles 1010.., 2: random valid/ready
    int abort_at;  // beats accepted before abort, -1 = none
    int midcfg;    // beat index at which a stray cfg_start is pulsed, -1 = none
    bit exp_err;
    int exp_beats;
    int exp_wins;
    int exp_px;
    int exp_rowd;
  } vec_t;

  tag_t exp_q[$];
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   win_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {bus.s_ready, bus.win_valid, bus.win_cg, bus.win_col, bus.win_row, bus.win_last,
            lb_clr, lb_en, lb_px_depth, lb_row_depth, busy, done, cfg_err};
  endfunction

  // Window monitor: every win_valid must match the oldest expected tag.
  always @(negedge clk) begin
    tag_t e;
    if (rst === 1'b0 && bus.win_valid === 1'b1) begin
      win_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL win_unexpected: win_valid=1 tag %0h, required no window (t=%0t)",
                 {bus.win_cg, bus.win_col, bus.win_row, bus.win_last}, $time);
      end else begin
        e = exp_q.pop_front();
        check("win_tag", {bus.win_cg, bus.win_col, bus.win_row, bus.win_last}, e);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int   total, stop, k, cyc, budget, n_en, w0, cg, col, row;
    bit   sv, mr;
    total  = v.cin * v.w * v.h;
    stop   = (v.abort_at >= 0) ? v.abort_at : total;
    budget = 8 * stop + 50;
    k = 0; cyc = 0; n_en = 0;
    w0 = win_seen;

    step();
    cfg_cin_groups = CG_W'(v.cin);
    cfg_width      = COL_W'(v.w);
    cfg_height     = ROW_W'(v.h);
    cfg_start      = 1'b1;
    bus.s_valid    = 1'b1;
    bus.m_ready    = 1'b1;
    @(negedge clk);
    check("idle_s_ready", bus.s_ready, 0);
    check("idle_lb_en", lb_en, 0);

    step();
    cfg_start = 1'b0;
    if (v.exp_err) begin
      abort = 1'b1;  // ignored in FINISH
      @(negedge clk);
      check("err_cfg_err", cfg_err, 1);
      check("err_lb_clr", lb_clr, 0);
      check("err_busy", busy, 1);
      check("err_done_early", done, 0);
      check("err_lb_en", lb_en, 0);
      step();
      abort = 1'b0;
      bus.s_valid = 1'b0;
      @(negedge clk);
      check("err_done", done, 1);
      check("err_busy_end", busy, 0);
      check("err_cfg_err_sticky", cfg_err, 1);
      return;
    end

    @(negedge clk);
    check("clr_lb_clr", lb_clr, 1);
    check("clr_busy", busy, 1);
    check("clr_cfg_err", cfg_err, 0);
    check("clr_s_ready", bus.s_ready, 0);
    check("clr_lb_en", lb_en, 0);
    check("px_depth", lb_px_depth, v.exp_px);
    check("row_depth", lb_row_depth, v.exp_rowd);

    while (k < stop && cyc < budget) begin
      step();
      case (v.mode)
        1:       begin sv = 1'b1; mr = (cyc % 2 == 0); end
        2:       begin sv = 1'($urandom_range(0, 1)); mr = 1'($urandom_range(0, 1)); end
        default: begin sv = 1'b1; mr = 1'b1; end
      endcase
      bus.s_valid = sv;
      bus.m_ready = mr;
      if (v.midcfg >= 0 && k == v.midcfg) begin
        cfg_start = 1'b1;
        cfg_cin_groups = CG_W'(1);
        cfg_width = COL_W'(3);
        cfg_height = ROW_W'(3);
      end else begin
        cfg_start = 1'b0;
      end
      @(negedge clk);
      check("run_s_ready", bus.s_ready, mr);
      check("run_lb_en", lb_en, sv && mr);
      if (lb_en === 1'b1) n_en++;
      if (sv && mr) begin
        cg  = k % v.cin;
        col = (k / v.cin) % v.w;
        row = k / (v.cin * v.w);
        if (row >= 2 && col >= 2)
          exp_q.push_back({8'(cg), 10'(col), 10'(row), (k == total - 1)});
        k++;
      end
      cyc++;
    end
    if (k < stop) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_timeout: %0d beats accepted, required %0d", k, stop);
    end

    if (v.abort_at >= 0) begin
      step();
      cfg_start = 1'b0;
      abort = 1'b1;
      bus.s_valid = 1'b1;
      bus.m_ready = 1'b1;
      @(negedge clk);
      step();
      abort = 1'b0;
      bus.s_valid = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_lb_clr", lb_clr, 1);
      check("abort_win_valid", bus.win_valid, 0);
      check("abort_done", done, 0);
      step();
      @(negedge clk);
      check("abort_lb_clr_once", lb_clr, 0);
      check("abort_no_done", done, 0);
    end else begin
      step();
      cfg_start = 1'b0;
      bus.s_valid = 1'b0;
      @(negedge clk);
      check("fin_busy", busy, 1);
      check("fin_done_early", done, 0);
      step();
      @(negedge clk);
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      step();
      @(negedge clk);
      check("done_one_cycle", done, 0);
    end
    check("beats", n_en, v.exp_beats);
    check("windows", win_seen - w0, v.exp_wins);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{2, 4, 3, 0, -1, -1, 1'b0, 24, 4, 2, 8};
    vecs[1]  = '{2, 4, 3, 1, -1, -1, 1'b0, 24, 4, 2, 8};
    vecs[2]  = '{2, 2, 3, 0, -1, -1, 1'b1, 0, 0, 0, 0};
    vecs[3]  = '{0, 4, 3, 0, -1, -1, 1'b1, 0, 0, 0, 0};
    vecs[4]  = '{1, 5, 5, 0, 10, -1, 1'b0, 10, 0, 1, 5};
    vecs[5]  = '{1, 5, 5, 0, -1, -1, 1'b0, 25, 9, 1, 5};
    vecs[6]  = '{1, 5, 5, 0, 13, -1, 1'b0, 13, 1, 1, 5};
    vecs[7]  = '{129, 3, 3, 0, -1, -1, 1'b1, 0, 0, 0, 0};
    vecs[8]  = '{128, 3, 3, 0, -1, -1, 1'b0, 1152, 128, 128, 384};
    vecs[9]  = '{3, 5, 4, 2, -1, -1, 1'b0, 60, 18, 3, 15};
    vecs[10] = '{2, 4, 2, 0, -1, -1, 1'b1, 0, 0, 0, 0};
    vecs[11] = '{2, 4, 3, 0, -1, 7, 1'b0, 24, 4, 2, 8};
    vecs[12] = '{1, 3, 3, 1, -1, -1, 1'b0, 9, 1, 1, 3};

    // Reset with a legal start and live handshake: reset must win.
    rst = 1'b1;
    abort = 1'b0;
    cfg_start = 1'b1;
    cfg_cin_groups = 8'd2;
    cfg_width = 10'd4;
    cfg_height = 10'd3;
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    step();
    rst = 1'b0;
    cfg_start = 1'b0;
    bus.s_valid = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", all_outs(), 0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Reset in the middle of a frame (row 0 only, so no window is pending).
    step();
    cfg_cin_groups = 8'd2;
    cfg_width = 10'd4;
    cfg_height = 10'd3;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    repeat (6) step();
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("mid_rst_outputs", all_outs(), 0);
    step();
    rst = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    check("mid_rst_idle", all_outs(), 0);

    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "watchdog");
  end
endmodule
